// File: rtl/uart_tx_scheduler.sv
// Transmit scheduler: CPU writes fill a small byte FIFO, which is drained one byte
// at a time to the UART Sender through a tx_en / tx_status handshake with a watchdog.
module uart_tx_scheduler #(
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 1048575
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  tx_en,
  output logic [7:0]            tx_data,
  input  logic                  tx_status,
  output logic                  tx_done,
  output logic                  tx_err,
  output logic                  ovf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WD_W  = $clog2(TIMEOUT) + 1;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL   = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [WD_W-1:0]       WD_ONE     = WD_W'(1);
  localparam logic [WD_W-1:0]       WD_LAST    = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY
  } state_t;

  // tx_status comes from the bit-clock domain; only the second flop is used
  logic [1:0] sync_reg;
  logic       st_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], tx_status};
    end
  end

  assign st_s = sync_reg[1];

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic                  push;
  logic                  pop;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = wr_en & ~full & ~flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Fullness is judged on the pre-edge count, so a write into a full FIFO is
  // dropped even when a pop happens on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count      <= '0;
      ovf        <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count      <= '0;
      ovf        <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      if (wr_en && full) begin
        ovf <= 1'b1;
      end
    end
  end

  state_t          state_reg;
  state_t          state_next;
  logic [WD_W-1:0] wd_reg;
  logic [WD_W-1:0] wd_next;
  logic            tx_en_next;
  logic [7:0]      tx_data_next;
  logic            tx_done_next;
  logic            tx_err_next;

  always_comb begin
    state_next   = state_reg;
    wd_next      = wd_reg;
    tx_en_next   = tx_en;
    tx_data_next = tx_data;
    tx_done_next = 1'b0;
    tx_err_next  = tx_err & ~flush;
    pop          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable && !empty && !flush) begin
          tx_data_next = mem[rd_ptr_reg];
          pop          = 1'b1;
          tx_en_next   = 1'b1;
          wd_next      = '0;
          state_next   = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_next = wd_reg + WD_ONE;
        if (st_s) begin
          tx_en_next = 1'b0;
          state_next = BUSY;
        end else if (wd_reg == WD_LAST) begin
          // Sender never acknowledged: the byte is abandoned
          tx_en_next  = 1'b0;
          tx_err_next = 1'b1;
          state_next  = IDLE;
        end else if (flush) begin
          tx_en_next = 1'b0;
          state_next = IDLE;
        end
      end
      BUSY: begin
        tx_en_next = 1'b0;
        if (!st_s) begin
          tx_done_next = 1'b1;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        tx_en_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      wd_reg    <= '0;
      tx_en     <= 1'b0;
      tx_data   <= 8'h00;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      state_reg <= state_next;
      wd_reg    <= wd_next;
      tx_en     <= tx_en_next;
      tx_data   <= tx_data_next;
      tx_done   <= tx_done_next;
      tx_err    <= tx_err_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus randomized
// traffic checked against a queue-based model of the FIFO and handshake rules.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 8;
  localparam int TIMEOUT    = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       flush;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_status;
  logic       tx_done;
  logic       tx_err;
  logic       ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Sender model controls
  logic snd_on;
  logic snd_rand;
  int   snd_rise;
  int   snd_busy;

  // Passive monitor state
  int         done_total = 0;
  logic       mon_prev_en = 1'b0;
  logic [7:0] launch_log[$];

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_status(tx_status),
    .tx_done  (tx_done),
    .tx_err   (tx_err),
    .ovf      (ovf)
  );

  // Behavioural Sender: raise busy a number of cycles after a launch, hold, drop.
  initial begin : sender
    int  r;
    int  b;
    bit  ok;
    tx_status = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (reset !== 1'b1) begin
        tx_status = 1'b0;
      end else if (snd_on && tx_en && !tx_status) begin
        r  = snd_rand ? int'($urandom_range(1, 8)) : snd_rise;
        b  = snd_rand ? int'($urandom_range(4, 20)) : snd_busy;
        ok = 1'b1;
        for (int i = 0; i < r; i++) begin
          @(posedge clk);
          #2;
          if (!tx_en || reset !== 1'b1) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          tx_status = 1'b1;
          for (int i = 0; i < b; i++) begin
            @(posedge clk);
            #2;
            if (reset !== 1'b1) break;
          end
          tx_status = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    mon_prev_en <= tx_en;
    if (tx_done) done_total <= done_total + 1;
    if (tx_en && !mon_prev_en) launch_log.push_back(tx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] rv;
    rv = {1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    reset = 1'b0; enable = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    snd_on = 1'b0; snd_rand = 1'b0; snd_rise = 3; snd_busy = 10;
    repeat (3) tick();
    n_tests++;
    if ({tx_en, tx_data, full, empty, count, tx_done, tx_err, ovf} !== rv) begin
      n_fail++;
      $display("FAIL reset_values: got %b want %b",
               {tx_en, tx_data, full, empty, count, tx_done, tx_err, ovf}, rv);
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if ({empty, count, tx_en} !== {1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: empty/count/tx_en=%b/%0d/%b want 1/0/0", empty, count, tx_en);
    end
  endtask

  task automatic test_single_byte();
    int d0;
    int cyc;
    int got;
    enable = 1'b1; snd_on = 1'b1; snd_rand = 1'b0; snd_rise = 3; snd_busy = 100;
    d0 = done_total;
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    n_tests++;
    if ({count, empty, tx_en} !== {4'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_write: count/empty/tx_en=%0d/%b/%b want 1/0/0", count, empty, tx_en);
    end
    tick();
    n_tests++;
    if ({tx_en, tx_data, count} !== {1'b1, 8'hA5, 4'd0}) begin
      n_fail++;
      $display("FAIL single_launch: tx_en/tx_data/count=%b/%h/%0d want 1/a5/0", tx_en, tx_data, count);
    end
    repeat (5) tick();
    n_tests++;
    if (tx_en !== 1'b1) begin
      n_fail++;
      $display("FAIL single_en_hold: tx_en=%b want 1", tx_en);
    end
    tick();
    n_tests++;
    if (tx_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_en_fall: tx_en=%b want 0", tx_en);
    end
    cyc = 7;
    got = -1;
    for (int i = 0; i < 150 && got < 0; i++) begin
      tick();
      cyc++;
      if (tx_done) got = cyc;
    end
    n_tests++;
    if (got != 107) begin
      n_fail++;
      $display("FAIL single_done_time: cycle=%0d want 107", got);
    end
    tick();
    n_tests++;
    if (tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_width: tx_done=%b want 0", tx_done);
    end
    repeat (3) tick();
    n_tests++;
    if ({done_total - d0 == 1, empty} !== 2'b11) begin
      n_fail++;
      $display("FAIL single_done_count: dones=%0d empty=%b want 1/1", done_total - d0, empty);
    end
  endtask

  task automatic test_burst_full();
    int d0;
    int ls;
    logic [7:0] exp_b;
    enable = 1'b0; snd_on = 1'b1; snd_rand = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      if (i == 8) begin
        n_tests++;
        if ({full, count, ovf} !== {1'b1, 4'd8, 1'b0}) begin
          n_fail++;
          $display("FAIL burst_full8: full/count/ovf=%b/%0d/%b want 1/8/0", full, count, ovf);
        end
      end
    end
    wr_en = 1'b0;
    n_tests++;
    if ({ovf, count} !== {1'b1, 4'd8}) begin
      n_fail++;
      $display("FAIL burst_ovf: ovf/count=%b/%0d want 1/8", ovf, count);
    end
    ls = launch_log.size();
    d0 = done_total;
    enable = 1'b1;
    for (int i = 0; i < 600 && done_total - d0 < 8; i++) tick();
    repeat (20) tick();
    n_tests++;
    if (done_total - d0 != 8 || launch_log.size() - ls != 8) begin
      n_fail++;
      $display("FAIL burst_counts: dones=%0d launches=%0d want 8/8", done_total - d0, launch_log.size() - ls);
    end else begin
      for (int k = 0; k < 8; k++) begin
        exp_b = 8'(k + 1);
        n_tests++;
        if (launch_log[ls + k] !== exp_b) begin
          n_fail++;
          $display("FAIL burst_order[%0d]: got %h want %h", k, launch_log[ls + k], exp_b);
        end
      end
    end
    n_tests++;
    if ({empty, ovf} !== 2'b11) begin
      n_fail++;
      $display("FAIL burst_end: empty/ovf=%b/%b want 1/1", empty, ovf);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_flush_ovf: ovf=%b want 0", ovf);
    end
  endtask

  task automatic test_watchdog();
    int d0;
    snd_on = 1'b0; snd_rand = 1'b0; enable = 1'b1;
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    tick();
    n_tests++;
    if ({tx_en, tx_data} !== {1'b1, 8'h3C}) begin
      n_fail++;
      $display("FAIL wd_launch: tx_en/tx_data=%b/%h want 1/3c", tx_en, tx_data);
    end
    repeat (15) tick();
    n_tests++;
    if ({tx_en, tx_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL wd_before: tx_en/tx_err=%b/%b want 1/0", tx_en, tx_err);
    end
    tick();
    n_tests++;
    if ({tx_en, tx_err} !== 2'b01) begin
      n_fail++;
      $display("FAIL wd_expire: tx_en/tx_err=%b/%b want 0/1", tx_en, tx_err);
    end
    snd_on = 1'b1; snd_rise = 2; snd_busy = 6;
    d0 = done_total;
    wr_en = 1'b1; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 100 && done_total - d0 < 1; i++) tick();
    tick();
    n_tests++;
    if (done_total - d0 != 1 || launch_log[$] !== 8'h5A || tx_err !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_next_byte: dones=%0d last=%h tx_err=%b want 1/5a/1",
               done_total - d0, launch_log[$], tx_err);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (tx_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_flush_clear: tx_err=%b want 0", tx_err);
    end
  endtask

  task automatic test_flush();
    int d0;
    int ls;
    snd_on = 1'b0; snd_rand = 1'b0; enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h11 * (i + 1));
      tick();
    end
    wr_en = 1'b0;
    d0 = done_total;
    ls = launch_log.size();
    enable = 1'b1;
    tick();
    n_tests++;
    if ({tx_en, count} !== {1'b1, 4'd3}) begin
      n_fail++;
      $display("FAIL flush_setup: tx_en/count=%b/%0d want 1/3", tx_en, count);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if ({tx_en, count, empty} !== {1'b0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_launch: tx_en/count/empty=%b/%0d/%b want 0/0/1", tx_en, count, empty);
    end
    snd_on = 1'b1; snd_rise = 2; snd_busy = 10;
    repeat (30) tick();
    n_tests++;
    if (done_total != d0 || launch_log.size() - ls != 1 || tx_err !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_done: dones=%0d launches=%0d tx_err=%b want 0/1/0",
               done_total - d0, launch_log.size() - ls, tx_err);
    end
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 20 && !tx_en; i++) tick();
    n_tests++;
    if ({tx_en, tx_data} !== {1'b1, 8'h77}) begin
      n_fail++;
      $display("FAIL flush_busy_launch: tx_en/tx_data=%b/%h want 1/77", tx_en, tx_data);
    end
    for (int i = 0; i < 30 && tx_en; i++) tick();
    // In BUSY now: flush with a simultaneous write that must be dropped quietly
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    n_tests++;
    if ({count, ovf} !== {4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_wr_drop: count/ovf=%0d/%b want 0/0", count, ovf);
    end
    for (int i = 0; i < 40 && done_total - d0 < 1; i++) tick();
    repeat (10) tick();
    n_tests++;
    if (done_total - d0 != 1 || launch_log.size() - ls != 2) begin
      n_fail++;
      $display("FAIL flush_busy_done: dones=%0d launches=%0d want 1/2",
               done_total - d0, launch_log.size() - ls);
    end
  endtask

  task automatic test_push_pop();
    int d0;
    int ls;
    enable = 1'b0; snd_on = 1'b1; snd_rand = 1'b1;
    d0 = done_total;
    ls = launch_log.size();
    wr_en = 1'b1; wr_data = 8'hB1;
    tick();
    enable = 1'b1; wr_data = 8'hB2;
    tick();
    wr_en = 1'b0;
    n_tests++;
    if ({count, tx_en, tx_data} !== {4'd1, 1'b1, 8'hB1}) begin
      n_fail++;
      $display("FAIL pushpop_count: count/tx_en/tx_data=%0d/%b/%h want 1/1/b1", count, tx_en, tx_data);
    end
    for (int i = 0; i < 200 && done_total - d0 < 2; i++) tick();
    repeat (3) tick();
    n_tests++;
    if (launch_log.size() - ls != 2) begin
      n_fail++;
      $display("FAIL pushpop_launches: got %0d want 2", launch_log.size() - ls);
    end else begin
      n_tests++;
      if ({launch_log[ls], launch_log[ls + 1]} !== {8'hB1, 8'hB2}) begin
        n_fail++;
        $display("FAIL pushpop_order: got %h %h want b1 b2", launch_log[ls], launch_log[ls + 1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] rv;
    rv = {1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    snd_on = 1'b0; snd_rand = 1'b0; enable = 1'b1;
    wr_en = 1'b1; wr_data = 8'hD1;
    tick();
    wr_en = 1'b0;
    tick();
    n_tests++;
    if (tx_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_launch: tx_en=%b want 1", tx_en);
    end
    #3 reset = 1'b0;
    #1;
    n_tests++;
    if (tx_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async_en: tx_en=%b want 0", tx_en);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    snd_on = 1'b1; snd_rise = 2; snd_busy = 40;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hE1 + i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 30 && tx_en; i++) tick();
    n_tests++;
    if ({tx_en, count, tx_data} !== {1'b0, 4'd2, 8'hE1}) begin
      n_fail++;
      $display("FAIL rstmid_busy: tx_en/count/tx_data=%b/%0d/%h want 0/2/e1", tx_en, count, tx_data);
    end
    #3 reset = 1'b0;
    #1;
    n_tests++;
    if ({tx_en, tx_data, full, empty, count, tx_done, tx_err, ovf} !== rv) begin
      n_fail++;
      $display("FAIL rstmid_values: got %b want %b",
               {tx_en, tx_data, full, empty, count, tx_done, tx_err, ovf}, rv);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) tick();
    n_tests++;
    if ({empty, count, tx_en} !== {1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_release: empty/count/tx_en=%b/%0d/%b want 1/0/0", empty, count, tx_en);
    end
  endtask

  task automatic test_random_traffic();
    logic [7:0] q[$];
    logic [7:0] exp_b;
    logic [7:0] prev_data;
    logic [7:0] d;
    logic       prev_en;
    logic       w;
    logic       en;
    logic       mdl_ovf;
    logic       launch;
    int         sz;
    int         l_cnt;
    int         d_cnt;
    enable = 1'b1; snd_on = 1'b1; snd_rand = 1'b1;
    mdl_ovf = 1'b0; l_cnt = 0; d_cnt = 0;
    prev_en = tx_en; prev_data = tx_data;
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (cyc < 450) begin
        w  = ($urandom_range(0, 99) < 45);
        d  = 8'($urandom);
        en = ($urandom_range(0, 9) != 0);
      end else begin
        w = 1'b0; d = 8'h00; en = 1'b1;
      end
      wr_en = w; wr_data = d; enable = en;
      sz = q.size();
      tick();
      launch = tx_en && !prev_en;
      if (launch) begin
        l_cnt++;
        n_tests++;
        if (!en || sz == 0) begin
          n_fail++;
          $display("FAIL rnd_launch_cond: cyc=%0d enable=%b queued=%0d want enable=1 queued>0", cyc, en, sz);
        end else begin
          exp_b = q.pop_front();
          n_tests++;
          if (tx_data !== exp_b) begin
            n_fail++;
            $display("FAIL rnd_tx_data: cyc=%0d got %h want %h", cyc, tx_data, exp_b);
          end
        end
      end else begin
        n_tests++;
        if (tx_data !== prev_data) begin
          n_fail++;
          $display("FAIL rnd_data_hold: cyc=%0d got %h want %h", cyc, tx_data, prev_data);
        end
      end
      if (w) begin
        if (sz < DEPTH) q.push_back(d);
        else mdl_ovf = 1'b1;
      end
      if (tx_done) d_cnt++;
      n_tests++;
      if ({full, empty, count, ovf, tx_err} !==
          {q.size() == DEPTH, q.size() == 0, 4'(q.size()), mdl_ovf, 1'b0}) begin
        n_fail++;
        $display("FAIL rnd_status: cyc=%0d full/empty/count/ovf/err=%b/%b/%0d/%b/%b want %b/%b/%0d/%b/0",
                 cyc, full, empty, count, ovf, tx_err,
                 q.size() == DEPTH, q.size() == 0, q.size(), mdl_ovf);
      end
      prev_en = tx_en;
      prev_data = tx_data;
    end
    n_tests++;
    if (l_cnt != d_cnt || q.size() != 0 || l_cnt == 0) begin
      n_fail++;
      $display("FAIL rnd_drain: launches=%0d dones=%0d left=%0d want equal, nonzero, 0 left",
               l_cnt, d_cnt, q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_byte();
    test_burst_full();
    test_watchdog();
    test_flush();
    test_push_pop();
    test_reset_mid();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Transmit scheduler between the CPU-side peripheral bus and the UART `Sender`. Bytes written by the CPU go into a small FIFO. The scheduler drains the FIFO one byte at a time using a `tx_en`/`tx_status` handshake with the `Sender`. It also raises a completion pulse per byte, a watchdog error, and an overflow flag that the peripheral register block maps into its UART status and interrupt bits.

## Interface

Parameters:
- `DEPTH_LOG2`, default 3: FIFO depth = 2^DEPTH_LOG2 bytes (8).
- `TIMEOUT`, default 1048575: `clk` cycles allowed for `tx_status` to rise after `tx_en` asserts; must be ≥ 4.

Ports:
- `clk`  in  1  system clock; every register is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when 0, no new byte is launched; a transfer in progress completes.
- `flush`  in  1  one-cycle pulse; empties the FIFO and aborts an unacknowledged launch.
- `wr_en`  in  1  push `wr_data` into the FIFO.
- `wr_data`  in  8  byte to transmit.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  DEPTH_LOG2+1  FIFO occupancy.
- `tx_en`  out  1  launch request to `Sender`.
- `tx_data`  out  8  byte presented to `Sender`; held stable while `tx_en`=1 and during BUSY.
- `tx_status`  in  1  `Sender` busy flag from the `bot_clk` domain; treated as asynchronous.
- `tx_done`  out  1  one-cycle pulse when a byte finishes transmitting.
- `tx_err`  out  1  sticky; watchdog expired. Cleared only by `flush` or reset.
- `ovf`  out  1  sticky; a write was dropped because the FIFO was full. Cleared only by `flush` or reset.

## Operation

- `tx_status` passes through a 2-flop synchronizer; `st_s` is the second flop. The FSM uses only `st_s`.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit read/write pointers that wrap modulo depth.
  - `count` is registered.
  - `full` = (`count` == 2^DEPTH_LOG2); `empty` = (`count` == 0).
- Write handling:
  - A write with `full`=1 is dropped and sets `ovf`. This holds even if a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leaves `count` unchanged.
- FSM states: IDLE, LAUNCH, BUSY.
  - IDLE: if `enable` & ~`empty` & ~`flush`:
    - `tx_data` <= FIFO head.
    - Pop.
    - `tx_en` <= 1.
    - Clear watchdog.
    - Go to LAUNCH.
  - LAUNCH: `tx_en`=1; watchdog increments each cycle.
    - If `st_s`=1: `tx_en` <= 0, go to BUSY.
    - Else if watchdog == TIMEOUT-1: `tx_en` <= 0, set `tx_err`, go to IDLE. The byte is lost.
    - Else if `flush`: `tx_en` <= 0, go to IDLE. No `tx_err`.
  - BUSY: `tx_en`=0.
    - When `st_s`=0: pulse `tx_done`, go to IDLE.
    - `flush` does not abort BUSY; the byte on the line finishes.
- `flush`:
  - Zeroes the pointers, `count`, `ovf`, and `tx_err` in that cycle.
  - A write in the same cycle as `flush` is dropped and does not set `ovf`.
- Deasserting `enable` mid-LAUNCH or mid-BUSY does not interrupt the handshake.
- Reset mid-operation:
  - All state returns to reset values immediately. FIFO contents are discarded.
  - `tx_en` drops asynchronously.
- Reset values:
  - `tx_en`=0, `tx_data`=8'h00, `full`=0, `empty`=1, `count`=0, `tx_done`=0, `tx_err`=0, `ovf`=0.
  - FSM=IDLE, synchronizer flops=0, watchdog=0.

## Timing

- Write at edge N: `count`/`empty` update at N. IDLE launches at edge N+1, so `tx_en`=1 from N+1 with the byte on `tx_data`.
- `tx_status` rising at edge M is visible as `st_s` at M+2. `tx_en` falls at edge M+3 (the first edge at which LAUNCH samples `st_s`=1).
- `tx_status` falling is visible 2 edges later. `tx_done` is high for the one cycle after the next edge, and the FSM is in IDLE at the same time.
- Back-to-back bytes: a new launch can occur the edge after `tx_done` asserts. This gives a minimum 1-cycle IDLE between bytes.
- Watchdog: `tx_err` is set exactly TIMEOUT cycles after `tx_en` rises if `st_s` never goes high.
- `tx_data` changes only on the IDLE->LAUNCH transition.

## Test plan

- Single byte: reset, `enable`=1, write 8'hA5. Model `tx_status` high 3 cycles after `tx_en` and low 100 cycles later. Expect:
  - `tx_en` high 1 cycle after the write, with `tx_data`=8'hA5.
  - `tx_en` falls 3 cycles after `tx_status` rises.
  - One `tx_done` pulse; `empty`=1.
- Burst/full: with `enable`=0, write 9 bytes 8'h01..8'h09. Expect:
  - `full`=1 and `count`=8 after 8 writes.
  - The 9th write is dropped and `ovf`=1.
  - Raise `enable`: bytes 01..08 are sent in order with 8 `tx_done` pulses; 09 is never sent.
- Watchdog: set TIMEOUT=16, write 8'h3C, hold `tx_status`=0. Expect:
  - `tx_en` drops after 16 cycles and `tx_err`=1; FSM returns to IDLE.
  - The next byte launches normally.
- Flush: issue `flush` in LAUNCH with 3 bytes queued. Expect `tx_en`=0 next cycle, `count`=0, no `tx_done`. Issue `flush` in BUSY: the current byte completes with a `tx_done` pulse.
- Simultaneous push/pop: with `count`=1 in IDLE, write on the launch edge. Expect `count` stays 1 and byte order is preserved.
- Reset mid-BUSY: assert `reset` low asynchronously. Expect all outputs at reset values immediately, and `empty`=1 after release.
